// File: rtl/alu_seq_pkg.sv
// Shared widths, opcodes and FSM state type for the ALU command sequencer.
package alu_seq_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, ALU-drive and response bundle for alu_sequencer; slave is the sequencer side.
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic              cmd_valid_in;
    logic              cmd_ready_out;
    logic [DATA_W-1:0] cmd_a_in;
    logic [DATA_W-1:0] cmd_b_in;
    logic [OP_W-1:0]   cmd_op_in;
    logic              cmd_chain_in;

    logic [DATA_W-1:0] alu_a_out;
    logic [DATA_W-1:0] alu_b_out;
    logic [OP_W-1:0]   alu_op_out;
    logic [DATA_W-1:0] alu_y_in;
    logic              alu_z_in;

    logic              rsp_valid_out;
    logic              rsp_ready_in;
    logic [DATA_W-1:0] rsp_y_out;
    logic              rsp_z_out;

    modport slave (
        input  cmd_valid_in, cmd_a_in, cmd_b_in, cmd_op_in, cmd_chain_in,
        output cmd_ready_out,
        output alu_a_out, alu_b_out, alu_op_out,
        input  alu_y_in, alu_z_in,
        output rsp_valid_out, rsp_y_out, rsp_z_out,
        input  rsp_ready_in
    );

    modport master (
        output cmd_valid_in, cmd_a_in, cmd_b_in, cmd_op_in, cmd_chain_in,
        input  cmd_ready_out,
        input  alu_a_out, alu_b_out, alu_op_out,
        output alu_y_in, alu_z_in,
        input  rsp_valid_out, rsp_y_out, rsp_z_out,
        output rsp_ready_in
    );

endinterface

// File: rtl/alu_seq_fifo.sv
// Command FIFO with wrap-bit pointers; head entry is read combinationally so the
// sequencer can issue on the same edge it pops.
module alu_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands, drives one at a time into an external ALU and returns results.
// Optional operand chaining from the previous result is enabled by ALU_SEQ_CHAIN_EN.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    alu_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);
`ifdef ALU_SEQ_CHAIN_EN
    localparam int ENTRY_W = 2 * DATA_W + OP_W + 1;
`else
    localparam int ENTRY_W = 2 * DATA_W + OP_W;
`endif

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic [DATA_W-1:0]  head_a;
    logic [DATA_W-1:0]  head_b;
    logic [OP_W-1:0]    head_op;
    logic [DATA_W-1:0]  issue_a;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]  alu_a_reg;
    logic [DATA_W-1:0]  alu_b_reg;
    logic [OP_W-1:0]    alu_op_reg;
    logic [DATA_W-1:0]  rsp_y_reg;
    logic               rsp_z_reg;
    logic               rsp_valid_reg;

    assign push   = bus.cmd_valid_in && !fifo_full;
    assign head_a = head_data[2*DATA_W+OP_W-1 -: DATA_W];
    assign head_b = head_data[DATA_W+OP_W-1 -: DATA_W];
    assign head_op = head_data[OP_W-1:0];

`ifdef ALU_SEQ_CHAIN_EN
    logic head_chain;
    assign push_data  = {bus.cmd_chain_in, bus.cmd_a_in, bus.cmd_b_in, bus.cmd_op_in};
    assign head_chain = head_data[ENTRY_W-1];
    // rsp_y_reg always holds the most recently captured result, so it doubles as the chain source.
    assign issue_a    = head_chain ? rsp_y_reg : head_a;
`else
    logic unused_chain;
    assign unused_chain = bus.cmd_chain_in;
    assign push_data    = {bus.cmd_a_in, bus.cmd_b_in, bus.cmd_op_in};
    assign issue_a      = head_a;
`endif

    // Issue from IDLE, or straight from RESP on the edge the response is taken.
    assign pop = !fifo_empty &&
                 ((state_reg == IDLE) || ((state_reg == RESP) && bus.rsp_ready_in));

    alu_seq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= '0;
            rsp_y_reg     <= '0;
            rsp_z_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
        end else begin
            if (pop) begin
                alu_a_reg  <= issue_a;
                alu_b_reg  <= head_b;
                alu_op_reg <= head_op;
                cnt_reg    <= CNT_W'(ALU_LAT);
            end
            case (state_reg)
                IDLE: begin
                    if (pop) state_reg <= WAIT;
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        rsp_y_reg     <= bus.alu_y_in;
                        rsp_z_reg     <= bus.alu_z_in;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_in) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= pop ? WAIT : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_out = !fifo_full;
    assign bus.alu_a_out     = alu_a_reg;
    assign bus.alu_b_out     = alu_b_reg;
    assign bus.alu_op_out    = alu_op_reg;
    assign bus.rsp_y_out     = rsp_y_reg;
    assign bus.rsp_z_out     = rsp_z_reg;
    assign bus.rsp_valid_out = rsp_valid_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed and random commands against an in-order result model.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        chain;
    } cmd_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   rsp_count;
    logic [31:0] last_y;
    cmd_t exp_q[$];

    alu_sequencer_if bus();

    alu_sequencer #(.DEPTH(4), .ALU_LAT(1)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    // Combinational ALU: ADD/SUB with zero flag.
    assign bus.alu_y_in = (bus.alu_op_out == OP_SUB) ? bus.alu_a_out - bus.alu_b_out
                                                     : bus.alu_a_out + bus.alu_b_out;
    assign bus.alu_z_in = (bus.alu_y_in == 32'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_y(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        return (op == OP_SUB) ? a - b : a + b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted commands, check responses in order at the handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cmd_valid_in && bus.cmd_ready_out)
                exp_q.push_back('{bus.cmd_a_in, bus.cmd_b_in, bus.cmd_op_in, bus.cmd_chain_in});
            if (bus.rsp_valid_out && bus.rsp_ready_in) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_with_empty_model", exp_q.size(), 1);
                end else begin
                    cmd_t e;
                    logic [31:0] a_eff;
                    logic [31:0] y;
                    e = exp_q.pop_front();
`ifdef ALU_SEQ_CHAIN_EN
                    a_eff = e.chain ? last_y : e.a;
`else
                    a_eff = e.a;
`endif
                    y = ref_y(a_eff, e.b, e.op);
                    last_y = y;
                    chk("model_rsp_y", bus.rsp_y_out, y);
                    chk("model_rsp_z", bus.rsp_z_out, (y == 32'd0));
                    rsp_count++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic chain);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        bus.cmd_a_in     = a;
        bus.cmd_b_in     = b;
        bus.cmd_op_in    = op;
        bus.cmd_chain_in = chain;
        bus.cmd_valid_in = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.cmd_ready_out;
            tick();
            n++;
        end
        bus.cmd_valid_in = 1'b0;
        if (!ok) chk("send_timeout", ok, 1);
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!bus.rsp_valid_out && n < 50) begin
            tick();
            n++;
        end
        if (!bus.rsp_valid_out) chk({tag, "_timeout"}, bus.rsp_valid_out, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.rsp_ready_in = 1'b1;
        while ((exp_q.size() != 0 || bus.rsp_valid_out) && n < 500) begin
            tick();
            n++;
        end
        chk("drain_model_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t cmds[6];
        cmd_t c0;
        int   idx;
        int   base;
        int   sent;
        int   cyc;
        logic acc;
        logic [31:0] y0;

        tests = 0; fails = 0; rsp_count = 0; last_y = '0;
        rst_n = 1'b0;
        bus.cmd_valid_in = 1'b0; bus.cmd_a_in = '0; bus.cmd_b_in = '0;
        bus.cmd_op_in = '0; bus.cmd_chain_in = 1'b0; bus.rsp_ready_in = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_cmd_ready", bus.cmd_ready_out, 1);
        chk("rst_rsp_valid", bus.rsp_valid_out, 0);
        chk("rst_rsp_y", bus.rsp_y_out, 0);
        chk("rst_rsp_z", bus.rsp_z_out, 0);
        chk("rst_alu_a", bus.alu_a_out, 0);
        chk("rst_alu_b", bus.alu_b_out, 0);
        chk("rst_alu_op", bus.alu_op_out, 0);
        rst_n = 1'b1;
        tick();

        // 1+1 latency: operands after E1, response after E2
        bus.rsp_ready_in = 1'b1;
        send(32'd1, 32'd1, OP_ADD, 1'b0);
        chk("lat_e0_rsp_valid", bus.rsp_valid_out, 0);
        tick();
        chk("lat_e1_alu_a", bus.alu_a_out, 1);
        chk("lat_e1_alu_b", bus.alu_b_out, 1);
        chk("lat_e1_rsp_valid", bus.rsp_valid_out, 0);
        tick();
        chk("lat_e2_rsp_valid", bus.rsp_valid_out, 1);
        chk("add_rsp_y", bus.rsp_y_out, 2);
        chk("add_rsp_z", bus.rsp_z_out, 0);
        tick();
        chk("lat_e3_rsp_clear", bus.rsp_valid_out, 0);

        // 5-5 gives zero
        send(32'd5, 32'd5, OP_SUB, 1'b0);
        wait_rsp("sub");
        chk("sub_rsp_y", bus.rsp_y_out, 0);
        chk("sub_rsp_z", bus.rsp_z_out, 1);
        tick();
        drain();

        // Backpressure: six held commands, five accepted
        bus.rsp_ready_in = 1'b0;
        for (int i = 0; i < 6; i++)
            cmds[i] = '{$urandom, $urandom, 3'($urandom_range(0, 1)), 1'b0};
        idx = 0;
        bus.cmd_valid_in = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.cmd_a_in = cmds[idx].a; bus.cmd_b_in = cmds[idx].b;
            bus.cmd_op_in = cmds[idx].op; bus.cmd_chain_in = cmds[idx].chain;
            @(negedge clk);
            acc = bus.cmd_ready_out;
            tick();
            if (acc) idx++;
            if (idx == 6) break;
        end
        chk("full_accepted", idx, 5);
        chk("full_cmd_ready", bus.cmd_ready_out, 0);
        bus.cmd_valid_in = 1'b0;

        // RESP holds its outputs while stalled
        c0 = cmds[0];
        y0 = ref_y(c0.a, c0.b, c0.op);
        for (int c = 0; c < 10; c++) begin
            chk("hold_rsp_valid", bus.rsp_valid_out, 1);
            chk("hold_rsp_y", bus.rsp_y_out, y0);
            chk("hold_rsp_z", bus.rsp_z_out, (y0 == 32'd0));
            chk("hold_alu_a", bus.alu_a_out, c0.a);
            chk("hold_alu_b", bus.alu_b_out, c0.b);
            chk("hold_alu_op", bus.alu_op_out, c0.op);
            tick();
        end
        base = rsp_count;
        drain();
        chk("full_rsp_count", rsp_count - base, 5);

        // Chaining (ignored when the feature is compiled out)
        bus.rsp_ready_in = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
        send(32'd1, 32'd1, OP_ADD, 1'b0);
        send(32'd0, 32'd3, OP_ADD, 1'b1);
        wait_rsp("chain1");
        chk("chain_rsp1", bus.rsp_y_out, 2);
        tick();
        wait_rsp("chain2");
        chk("chain_rsp2", bus.rsp_y_out, 5);
        tick();
`else
        send(32'd7, 32'd3, OP_ADD, 1'b1);
        wait_rsp("nochain");
        chk("nochain_rsp", bus.rsp_y_out, 10);
        tick();
`endif
        drain();

        // Random traffic with random backpressure
        sent = 0;
        cyc = 0;
        base = rsp_count;
        while (sent < 30 && cyc < 2000) begin
            bus.rsp_ready_in = 1'($urandom_range(0, 1));
            if (!bus.cmd_valid_in && $urandom_range(0, 3) != 0) begin
                bus.cmd_a_in = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
                bus.cmd_b_in = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
                bus.cmd_op_in = 3'($urandom_range(0, 1));
                bus.cmd_chain_in = 1'($urandom_range(0, 1));
                bus.cmd_valid_in = 1'b1;
            end
            @(negedge clk);
            acc = bus.cmd_valid_in && bus.cmd_ready_out;
            tick();
            if (acc) begin
                sent++;
                bus.cmd_valid_in = 1'b0;
            end
            cyc++;
        end
        bus.cmd_valid_in = 1'b0;
        chk("rand_sent", sent, 30);
        drain();
        chk("rand_rsp_count", rsp_count - base, 30);

        // Reset during WAIT discards the command
        bus.rsp_ready_in = 1'b1;
        send(32'd9, 32'd9, OP_ADD, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", bus.rsp_valid_out, 0);
        chk("mid_rst_cmd_ready", bus.cmd_ready_out, 1);
        chk("mid_rst_alu_a", bus.alu_a_out, 0);
        exp_q.delete();
        last_y = '0;
        #1;
        rst_n = 1'b1;
        base = rsp_count;
        repeat (3) tick();
        chk("post_rst_no_rsp", bus.rsp_valid_out, 0);
        send(32'd2, 32'd2, OP_ADD, 1'b0);
        wait_rsp("post_rst");
        chk("post_rst_rsp_y", bus.rsp_y_out, 4);
        tick();
        drain();
        chk("post_rst_rsp_count", rsp_count - base, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter ALU_LAT, default 1, cycles operands are held before the ALU result is sampled (>=1).
REQ-003 SHALL have port clk_in  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n_in  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports cmd_valid_in input 1 and cmd_ready_out output 1, the command handshake.
REQ-006 SHALL have ports cmd_a_in input 32, cmd_b_in input 32 and cmd_op_in input 3, the command operands and opcode.
REQ-007 SHALL have port cmd_chain_in  input  1  use previous result as operand a.
REQ-008 SHALL have ports alu_a_out output 32, alu_b_out output 32 and alu_op_out output 3, which drive the ALU a_in/b_in/op_in.
REQ-009 SHALL have ports alu_y_in input 32 and alu_z_in input 1, the ALU y_out/z_out.
REQ-010 SHALL have ports rsp_valid_out output 1 and rsp_ready_in input 1, the response handshake.
REQ-011 SHALL have ports rsp_y_out output 32 and rsp_z_out output 1, the captured result and zero flag.

Function
REQ-012 SHALL accept a command on any edge where cmd_valid_in && cmd_ready_out, writing it to FIFO tail.
REQ-013 SHALL drive cmd_ready_out = !full combinationally from registered FIFO state; a same-cycle pop SHALL NOT allow a push when full.
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-015 IDLE and FIFO non-empty: next edge SHALL pop head, register alu_a/b/op_out, load counter = ALU_LAT, go WAIT.
REQ-016 WAIT: counter SHALL decrement each edge; on the edge where counter == 1 it SHALL capture alu_y_in/alu_z_in into rsp_y_out/rsp_z_out, set rsp_valid_out, go RESP.
REQ-017 RESP: rsp_valid_out, rsp_y_out and rsp_z_out SHALL hold until rsp_ready_in is high at an edge.
REQ-018 On that edge: rsp_valid_out SHALL clear; if FIFO non-empty, pop and issue as in REQ-015 (straight to WAIT); else go IDLE.
REQ-019 Latency SHALL be: accept at edge E0 into empty IDLE block -> operands valid after E1 -> rsp_valid_out high after E(1+ALU_LAT).
REQ-020 Sustained throughput SHALL be one command per ALU_LAT+1 cycles with rsp_ready_in held high.
REQ-021 alu_*_out SHALL hold their last issued values while IDLE or RESP (operands never glitch mid-WAIT).
REQ-022 Command order SHALL be preserved; no command SHALL be dropped or duplicated under any backpressure.
REQ-023 Capacity SHALL be DEPTH queued plus one in flight.

Reset
REQ-024 rst_n_in low SHALL asynchronously clear FIFO pointers, FSM to IDLE, counter, alu_a/b/op_out, rsp_y_out, rsp_z_out and rsp_valid_out to 0; cmd_ready_out reads 1.
REQ-025 Reset mid-operation SHALL discard queued and in-flight commands without emitting a response.

Configuration
REQ-026 Macro ALU_SEQ_CHAIN_EN defined: FIFO SHALL store cmd_chain_in; on issue with chain=1, alu_a_out SHALL load the last captured rsp_y_out (0 after reset) instead of the stored a.
REQ-027 Macro undefined: cmd_chain_in SHALL be ignored and not stored; alu_a_out always loads stored a.

Structure
REQ-028 Package alu_seq_pkg SHALL hold DATA_W = 32, OP_W = 3, opcode constants (OP_ADD = 3'b000, OP_SUB = 3'b001) and the FSM state enum.
REQ-029 FIFO SHALL be sub-module alu_seq_fifo (parameterised width/depth, push/pop/full/empty).

Verification (ALU model: combinational ADD/SUB, z = (y == 0); ALU_LAT = 1, DEPTH = 4)
REQ-030 Reset; a=1, b=1, op=000, rsp_ready=1 -> rsp_y=2, rsp_z=0, rsp_valid high exactly 2 cycles after accept.
REQ-031 a=5, b=5, op=001 -> rsp_y=0, rsp_z=1.
REQ-032 rsp_ready=0, cmd_valid held with 6 distinct commands -> exactly 5 accepted, then cmd_ready=0; release rsp_ready -> 5 responses in order, values correct.
REQ-033 RESP held 10 cycles with rsp_ready=0 -> rsp_y/rsp_z/alu_*_out stable every cycle.
REQ-034 With ALU_SEQ_CHAIN_EN: cmd1 1+1, cmd2 chain=1, b=3, op=000 -> responses 2 then 5.
REQ-035 rst_n_in pulsed low during WAIT -> rsp_valid=0, cmd_ready=1 immediately; a following 2+2 returns 4.
